inst_queue: RTL and testbench

- Parametrised successor to the single-entry current-instruction register: a DEPTH-entry first-word-fall-through instruction buffer between instruction memory and decode.
- Captures fetched instruction words and presents the oldest to decode with a valid/accept handshake.
- Pulses pc_enable on every captured word, so the PC advances only when a fetch is actually stored.
- flush (branch or redirect) discards all buffered words.

---
 rtl/iq_pkg.sv | 9 +
 rtl/iq_mem.sv | 28 ++
 rtl/inst_queue.sv | 91 +++++++++
 tb/tb_inst_queue.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
// rtl/iq_pkg.sv - shared instruction word width, queue depth and word type for fetch, queue and decode
package iq_pkg;

  localparam int IQ_INST_W = 36;
  localparam int IQ_DEPTH  = 4;

  typedef logic [IQ_INST_W-1:0] inst_t;

endpackage

// File: rtl/iq_mem.sv
// rtl/iq_mem.sv - DEPTH x INST_W register array, one write port and one asynchronous read port
module iq_mem
  import iq_pkg::*;
#(
  parameter int INST_W = IQ_INST_W,
  parameter int DEPTH  = IQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [INST_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [INST_W-1:0] o_rdata
);

  // Contents are deliberately not reset; validity is tracked by the queue's count.
  logic [INST_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - FWFT instruction buffer between fetch and decode; IQ_BYPASS_EN adds an empty-queue bypass
module inst_queue
  import iq_pkg::*;
#(
  parameter int INST_W = IQ_INST_W,
  parameter int DEPTH  = IQ_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [INST_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [INST_W-1:0] rd_data,
  input  logic              rd_en,
  output logic [CNT_W-1:0]  count,
  output logic              pc_enable
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_bypass;
  logic              w_store;
  logic              w_drain;
  logic [INST_W-1:0] w_mem_rdata;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign wr_ready = !w_full;
  assign w_push   = wr_en && !w_full && !flush && !rst;
  assign w_pop    = rd_en && rd_valid && !flush && !rst;

`ifdef IQ_BYPASS_EN
  // An empty queue forwards the incoming word; if decode takes it, it is never stored.
  assign w_bypass = w_empty && w_push && rd_en;
  assign rd_valid = !w_empty || w_push;
  assign rd_data  = !w_empty ? w_mem_rdata : (w_push ? wr_data : '0);
`else
  assign w_bypass = 1'b0;
  assign rd_valid = !w_empty;
  assign rd_data  = rd_valid ? w_mem_rdata : '0;
`endif

  assign w_store   = w_push && !w_bypass;
  assign w_drain   = w_pop && !w_bypass;
  assign pc_enable = w_push;
  assign count     = r_count;

  iq_mem #(
    .INST_W (INST_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_store),
    .i_waddr (r_wr_ptr),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_drain) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_store, w_drain})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
    assert (r_count <= CNT_W'(DEPTH));
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - scoreboard bench for inst_queue (default build and IQ_BYPASS_EN build)
module tb_inst_queue;
  import iq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  inst_t       wr_data = '0;
  logic        wr_ready;
  logic        rd_valid;
  inst_t       rd_data;
  logic        rd_en = 1'b0;
  logic [2:0]  count;
  logic        pc_enable;

  int checks = 0;
  int errors = 0;
  inst_t sb_q[$];

  inst_queue #(.INST_W(36), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_en     (rd_en),
    .count     (count),
    .pc_enable (pc_enable)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head word must match the oldest expected word.
  always @(negedge clk) begin
    if (rd_valid && rd_en && !flush && !rst) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got 0x%0h expected none", rd_data);
      end else begin
        check("rd_data_order", rd_data, sb_q.pop_front());
      end
    end
  end

  // Drive one cycle's inputs, check pc_enable mid-cycle, then advance past the edge.
  task automatic step(input logic we, input logic [35:0] wd, input logic re,
                      input logic fl, input logic rs, input logic exp_pc, input string name);
    wr_en = we; wr_data = wd; rd_en = re; flush = fl; rst = rs;
    @(negedge clk);
    check(name, {35'd0, pc_enable}, {35'd0, exp_pc});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input string name, input logic [2:0] exp_cnt,
                            input logic exp_valid, input logic exp_ready);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; rst = 1'b0;
    #1;
    check({name, "_count"}, {33'd0, count}, {33'd0, exp_cnt});
    check({name, "_rd_valid"}, {35'd0, rd_valid}, {35'd0, exp_valid});
    check({name, "_wr_ready"}, {35'd0, wr_ready}, {35'd0, exp_ready});
  endtask

  initial begin
    @(posedge clk); #1;
    step(1'b0, 36'h0, 1'b0, 1'b0, 1'b1, 1'b0, "pc_in_reset0");
    step(1'b1, 36'h9, 1'b0, 1'b0, 1'b1, 1'b0, "pc_in_reset1");
    idle_check("after_reset", 3'd0, 1'b0, 1'b1);
    check("after_reset_rd_data", rd_data, 36'h0);

    // Fill with 1..4, then a fifth word is refused
    for (int i = 1; i <= 4; i++) begin
      sb_q.push_back(36'(i));
      step(1'b1, 36'(i), 1'b0, 1'b0, 1'b0, 1'b1, "fill_pc");
    end
    idle_check("full", 3'd4, 1'b1, 1'b0);
    step(1'b1, 36'h5, 1'b0, 1'b0, 1'b0, 1'b0, "full_push_ignored_pc");
    check("full_count_hold", {33'd0, count}, 36'd4);

    // Drain in order; a pop while full still cannot admit a write the same cycle
    step(1'b1, 36'h5, 1'b1, 1'b0, 1'b0, 1'b0, "pop_full_no_push_pc");
    for (int i = 0; i < 3; i++) step(1'b0, 36'h0, 1'b1, 1'b0, 1'b0, 1'b0, "drain_pc");
    idle_check("drained", 3'd0, 1'b0, 1'b1);
    check("drained_rd_data", rd_data, 36'h0);
    step(1'b0, 36'h0, 1'b1, 1'b0, 1'b0, 1'b0, "empty_rd_ignored_pc");
    check("empty_rd_count", {33'd0, count}, 36'd0);

    // Steady stream 0x10..0x19, pointers wrap twice
    sb_q.push_back(36'h10);
    step(1'b1, 36'h10, 1'b0, 1'b0, 1'b0, 1'b1, "stream_first_pc");
    for (int i = 1; i < 10; i++) begin
      sb_q.push_back(36'(16 + i));
      step(1'b1, 36'(16 + i), 1'b1, 1'b0, 1'b0, 1'b1, "stream_pc");
      check("stream_count", {33'd0, count}, 36'd1);
    end
    step(1'b0, 36'h0, 1'b1, 1'b0, 1'b0, 1'b0, "stream_tail_pc");
    check("stream_end_count", {33'd0, count}, 36'd0);

    // Flush priority over push and pop
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(36'(32 + i));
      step(1'b1, 36'(32 + i), 1'b0, 1'b0, 1'b0, 1'b1, "preflush_pc");
    end
    check("preflush_count", {33'd0, count}, 36'd3);
    sb_q.delete();
    step(1'b1, 36'hAA, 1'b1, 1'b1, 1'b0, 1'b0, "flush_pc");
    idle_check("after_flush", 3'd0, 1'b0, 1'b1);
    check("after_flush_rd_data", rd_data, 36'h0);
    step(1'b0, 36'h0, 1'b1, 1'b0, 1'b0, 1'b0, "post_flush_idle_pc");

    // Reset mid-stream with a write presented
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back(36'(48 + i));
      step(1'b1, 36'(48 + i), 1'b0, 1'b0, 1'b0, 1'b1, "prerst_pc");
    end
    check("prerst_count", {33'd0, count}, 36'd2);
    sb_q.delete();
    step(1'b1, 36'h32, 1'b0, 1'b0, 1'b1, 1'b0, "rst_mid_pc");
    idle_check("after_rst_mid", 3'd0, 1'b0, 1'b1);
    check("after_rst_mid_rd_data", rd_data, 36'h0);
    sb_q.push_back(36'h7);
    step(1'b1, 36'h7, 1'b0, 1'b0, 1'b0, 1'b1, "push7_pc");
    check("head7_valid", {35'd0, rd_valid}, 36'd1);
    check("head7_data", rd_data, 36'h7);
    step(1'b0, 36'h0, 1'b1, 1'b0, 1'b0, 1'b0, "pop7_pc");

    // Empty queue, write and read together
    sb_q.push_back(36'h55);
    wr_en = 1'b1; wr_data = 36'h55; rd_en = 1'b1; flush = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("byp_pc", {35'd0, pc_enable}, 36'd1);
`ifdef IQ_BYPASS_EN
    check("byp_valid_same_cycle", {35'd0, rd_valid}, 36'd1);
    check("byp_data_same_cycle", rd_data, 36'h55);
    @(posedge clk); #1;
    idle_check("byp_after", 3'd0, 1'b0, 1'b1);
`else
    check("nobyp_valid_same_cycle", {35'd0, rd_valid}, 36'd0);
    check("nobyp_data_same_cycle", rd_data, 36'h0);
    @(posedge clk); #1;
    idle_check("nobyp_after", 3'd1, 1'b1, 1'b1);
    check("nobyp_data_next", rd_data, 36'h55);
    step(1'b0, 36'h0, 1'b1, 1'b0, 1'b0, 1'b0, "nobyp_pop_pc");
`endif

    step(1'b0, 36'h0, 1'b0, 1'b0, 1'b0, 1'b0, "final_idle_pc");
    check("scoreboard_empty", 36'(sb_q.size()), 36'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
